processador_multiciclo_param: RTL and testbench

//  Parametrised successor of the 8x16-bit multicycle processor: NREGS general registers of DATA_W bits, A, G, shared bus.

---
 rtl/processador_multiciclo_param.sv | 138 +++++++++++++
 tb/tb_processador_multiciclo_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/processador_multiciclo_param.sv
// Parametrised multicycle CPU core: NREGS x DATA_W register file, A/G registers and one shared bus.
// Each instruction is fetched from DIN in T0 and executes over T1..T3; Done marks its final step.
module processador_multiciclo_param #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic              Done,
  output logic [DATA_W-1:0] BusWires,
  output logic [1:0]        Tstep,
  output logic [DATA_W-1:0] Rx_data,
  output logic [DATA_W-1:0] Ry_data
);
  localparam int RB  = $clog2(NREGS);
  localparam int IW  = 3 + 2 * RB;
  localparam int SHW = $clog2(DATA_W);

  typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
  typedef enum logic [2:0] {
    OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND, OP_SLT, OP_MVNZ, OP_SLL
  } op_t;
  typedef enum logic [2:0] {SEL_NONE, SEL_RX, SEL_RY, SEL_G, SEL_DIN} bus_sel_t;

  step_t               step_q, step_d;
  logic [IW-1:0]       ir_q;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [DATA_W-1:0]   a_q, g_q, alu_res;
  op_t                 op;
  logic [RB-1:0]       rx, ry;
  bus_sel_t            bus_sel;
  logic                ir_wr, rx_wr, a_wr, g_wr, done;

  assign op = op_t'(ir_q[IW-1 -: 3]);
  assign rx = ir_q[2*RB-1:RB];
  assign ry = ir_q[RB-1:0];

  assign Rx_data = regs[rx];
  assign Ry_data = regs[ry];
  assign Tstep   = step_q;
  assign Done    = done;

  // Step sequencing and per-step control; the step register is the only FSM state.
  always_comb begin
    step_d  = step_q;
    bus_sel = SEL_NONE;
    ir_wr   = 1'b0;
    rx_wr   = 1'b0;
    a_wr    = 1'b0;
    g_wr    = 1'b0;
    done    = 1'b0;
    case (step_q)
      T0: begin
        if (Run) begin
          ir_wr  = 1'b1;
          step_d = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV: begin
            bus_sel = SEL_RY;
            rx_wr   = 1'b1;
            done    = 1'b1;
          end
          OP_MVI: begin
            bus_sel = SEL_DIN;
            rx_wr   = 1'b1;
            done    = 1'b1;
          end
          OP_MVNZ: begin
            if (g_q != '0) begin
              bus_sel = SEL_RY;
              rx_wr   = 1'b1;
            end
            done = 1'b1;
          end
          default: begin
            bus_sel = SEL_RX;
            a_wr    = 1'b1;
            step_d  = T2;
          end
        endcase
      end
      T2: begin
        bus_sel = SEL_RY;
        g_wr    = 1'b1;
        step_d  = T3;
      end
      T3: begin
        bus_sel = SEL_G;
        rx_wr   = 1'b1;
        done    = 1'b1;
      end
      default: step_d = T0;
    endcase
    if (done) step_d = T0;
  end

  always_comb begin
    case (bus_sel)
      SEL_RX:  BusWires = regs[rx];
      SEL_RY:  BusWires = regs[ry];
      SEL_G:   BusWires = g_q;
      SEL_DIN: BusWires = DIN;
      default: BusWires = '0;
    endcase
  end

  // Second operand always comes from the bus in T2; the shift amount is truncated to SHW bits.
  always_comb begin
    case (op)
      OP_SUB:  alu_res = a_q - BusWires;
      OP_AND:  alu_res = a_q & BusWires;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(BusWires))};
      OP_SLL:  alu_res = a_q << BusWires[SHW-1:0];
      default: alu_res = a_q + BusWires;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      step_q <= T0;
      ir_q   <= '0;
      a_q    <= '0;
      g_q    <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      step_q <= step_d;
      if (ir_wr) ir_q <= DIN[IW-1:0];
      if (a_wr)  a_q  <= BusWires;
      if (g_wr)  g_q  <= alu_res;
      if (rx_wr) regs[rx] <= BusWires;
    end
  end
endmodule

// File: tb/tb_processador_multiciclo_param.sv
// Directed bench for processador_multiciclo_param (DATA_W=16, NREGS=8): instruction-level model
// predicts step, Done, bus and operand reads for every cycle; a negedge process compares them.
module tb_processador_multiciclo_param;
  localparam logic [2:0] OP_MV = 3'd0, OP_MVI = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4, OP_SLT = 3'd5, OP_MVNZ = 3'd6, OP_SLL = 3'd7;

  typedef struct packed {
    logic [1:0]  step;
    logic        done;
    logic [15:0] bus;
    logic        chk;
    logic [15:0] rx;
    logic [15:0] ry;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Run   = 1'b0;
  logic [15:0] DIN   = '0;
  logic        Done;
  logic [15:0] BusWires;
  logic [1:0]  Tstep;
  logic [15:0] Rx_data, Ry_data;

  exp_t        exp_q[$];
  exp_t        cur_e;
  logic [15:0] m_r [8];
  logic [15:0] m_g;
  int          vectors = 0;
  int          miscompares = 0;

  processador_multiciclo_param #(.DATA_W(16), .NREGS(8)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN), .Done(Done),
    .BusWires(BusWires), .Tstep(Tstep), .Rx_data(Rx_data), .Ry_data(Ry_data)
  );

  // Clock / reset
  always #5 Clock = ~Clock;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: one expectation per cycle, checked mid-cycle.
  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      cur_e = exp_q.pop_front();
      cmp("tstep", {14'd0, Tstep}, {14'd0, cur_e.step});
      cmp("done", {15'd0, Done}, {15'd0, cur_e.done});
      cmp("bus", BusWires, cur_e.bus);
      if (cur_e.chk) begin
        cmp("rx_data", Rx_data, cur_e.rx);
        cmp("ry_data", Ry_data, cur_e.ry);
      end
    end
  end

  function automatic exp_t mk(input logic [1:0] s, input logic d, input logic [15:0] b,
                              input logic c, input logic [15:0] rxv, input logic [15:0] ryv);
    exp_t e;
    e.step = s; e.done = d; e.bus = b; e.chk = c; e.rx = rxv; e.ry = ryv;
    return e;
  endfunction

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_SLT:  return (int'($signed(a)) < int'($signed(b))) ? 16'd1 : 16'd0;
      OP_SLL:  return a << (b % 16);
      default: return a + b;
    endcase
  endfunction

  function automatic logic [15:0] rnd16();
    return 16'($urandom_range(0, 65535));
  endfunction

  // Driver tasks
  task automatic drive(input logic run, input logic [15:0] din, input exp_t e);
    Run = run;
    DIN = din;
    exp_q.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_g = '0;
  endtask

  // Runs one instruction; Run is held high in T1..T3 and DIN is noise outside T0 / mvi-T1.
  task automatic exec(input logic [2:0] op, input int x, input int y, input logic [15:0] imm);
    logic [15:0] rxv, ryv, res;
    logic [8:0]  ins;
    ins = {op, 3'(x), 3'(y)};
    rxv = m_r[x];
    ryv = m_r[y];
    drive(1'b1, {7'($urandom_range(0, 127)), ins}, mk(2'd0, 1'b0, 16'd0, 1'b0, 16'd0, 16'd0));
    case (op)
      OP_MV: begin
        drive(1'b1, rnd16(), mk(2'd1, 1'b1, ryv, 1'b1, rxv, ryv));
        m_r[x] = ryv;
      end
      OP_MVI: begin
        drive(1'b1, imm, mk(2'd1, 1'b1, imm, 1'b1, rxv, ryv));
        m_r[x] = imm;
      end
      OP_MVNZ: begin
        if (m_g != 16'd0) begin
          drive(1'b1, rnd16(), mk(2'd1, 1'b1, ryv, 1'b1, rxv, ryv));
          m_r[x] = ryv;
        end else begin
          drive(1'b1, rnd16(), mk(2'd1, 1'b1, 16'd0, 1'b1, rxv, ryv));
        end
      end
      default: begin
        res = alu(op, rxv, ryv);
        drive(1'b1, rnd16(), mk(2'd1, 1'b0, rxv, 1'b1, rxv, ryv));
        drive(1'b1, rnd16(), mk(2'd2, 1'b0, ryv, 1'b0, 16'd0, 16'd0));
        drive(1'b1, rnd16(), mk(2'd3, 1'b1, res, 1'b0, 16'd0, 16'd0));
        m_g = res;
        m_r[x] = res;
      end
    endcase
    Run = 1'b0;
  endtask

  // mv Ri,Ri puts R[i] on the bus in T1 without changing it.
  task automatic dump_regs();
    for (int i = 0; i < 8; i++) exec(OP_MV, i, i, 16'd0);
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    cmp("reset_tstep", {14'd0, Tstep}, 16'd0);
    cmp("reset_done", {15'd0, Done}, 16'd0);
    cmp("reset_bus", BusWires, 16'd0);
    cmp("reset_rx", Rx_data, 16'd0);

    exec(OP_MVI, 0, 0, 16'h0005);
    cmp("mvi_r0_lit", Rx_data, 16'h0005);
    exec(OP_MVI, 1, 0, 16'h0007);
    exec(OP_ADD, 0, 1, 16'd0);
    cmp("add_r0_lit", Rx_data, 16'h000C);

    exec(OP_MVI, 2, 0, 16'h0000);
    exec(OP_MVI, 3, 0, 16'h0001);
    exec(OP_SUB, 2, 3, 16'd0);
    cmp("sub_wrap_lit", Rx_data, 16'hFFFF);
    exec(OP_MV, 4, 2, 16'd0);
    exec(OP_SLT, 4, 3, 16'd0);
    cmp("slt_neg_lit", Rx_data, 16'h0001);

    exec(OP_SUB, 5, 5, 16'd0);
    exec(OP_MVNZ, 6, 1, 16'd0);
    cmp("mvnz_g0_lit", Rx_data, 16'h0000);
    exec(OP_MVI, 7, 0, 16'h0005);
    exec(OP_ADD, 7, 1, 16'd0);
    exec(OP_MVNZ, 6, 1, 16'd0);
    cmp("mvnz_gnz_lit", Rx_data, 16'h0007);

    exec(OP_MVI, 5, 0, 16'h0F3C);
    exec(OP_MVI, 2, 0, 16'h00F0);
    exec(OP_AND, 2, 5, 16'd0);
    cmp("and_lit", Rx_data, 16'h0030);
    exec(OP_MVI, 3, 0, 16'h0013);
    exec(OP_MVI, 4, 0, 16'h1001);
    exec(OP_SLL, 4, 3, 16'd0);
    cmp("sll_trunc_lit", Rx_data, 16'h8008);
    exec(OP_SLT, 0, 1, 16'd0);
    cmp("slt_ge_lit", Rx_data, 16'h0000);
    exec(OP_ADD, 1, 1, 16'd0);
    cmp("add_same_reg_lit", Rx_data, 16'h000E);

    // Idle in T0 with Run low and noisy DIN.
    for (int i = 0; i < 20; i++)
      drive(1'b0, rnd16(), mk(2'd0, 1'b0, 16'd0, 1'b0, 16'd0, 16'd0));
    dump_regs();

    // Reset during T2 of add R1,R7 aborts the write-back.
    drive(1'b1, {7'd0, OP_ADD, 3'd1, 3'd7}, mk(2'd0, 1'b0, 16'd0, 1'b0, 16'd0, 16'd0));
    drive(1'b0, rnd16(), mk(2'd1, 1'b0, m_r[1], 1'b1, m_r[1], m_r[7]));
    Reset = 1'b1;
    drive(1'b1, rnd16(), mk(2'd2, 1'b0, m_r[7], 1'b0, 16'd0, 16'd0));
    Reset = 1'b0;
    model_clear();
    drive(1'b0, rnd16(), mk(2'd0, 1'b0, 16'd0, 1'b1, 16'd0, 16'd0));
    dump_regs();
    exec(OP_MVNZ, 1, 2, 16'd0);
    exec(OP_MVI, 3, 0, 16'h1234);

    // Reset and Run together in T0: Reset wins.
    Reset = 1'b1;
    Run   = 1'b1;
    DIN   = {7'd0, OP_MVI, 3'd5, 3'd0};
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    Run   = 1'b0;
    model_clear();
    cmp("reset_run_tstep", {14'd0, Tstep}, 16'd0);
    cmp("reset_run_rx", Rx_data, 16'd0);
    drive(1'b0, rnd16(), mk(2'd0, 1'b0, 16'd0, 1'b1, 16'd0, 16'd0));
    dump_regs();

    @(negedge Clock);
    cmp("exp_q_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
